// File: rtl/md_pkg.sv
// md_unit shared types: op codes, FSM states, divide-by-zero LO value.
// Build option: MD_FAST_MUL_EN selects a single-cycle multiplier in md_unit.
package md_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_ITER = 2'b01,
    MD_FIX  = 2'b10
  } md_state_e;

  localparam logic [31:0] MD_DIVZERO_LO = 32'hFFFFFFFF;

  function automatic logic md_is_signed(md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic md_is_div(md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_div_core.sv
// Restoring divider datapath: one quotient bit per step on magnitudes.
// Quotient register starts as the dividend and shifts quotient bits in.
module md_div_core
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_quo,
  output logic [WIDTH-1:0] o_rem
);

  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH:0]   w_part;
  logic [WIDTH:0]   w_diff;
  logic             w_ok;

  assign w_part = {r_rem, r_quo[WIDTH-1]};
  assign w_ok   = (w_part >= {1'b0, r_dvs});
  assign w_diff = w_part - {1'b0, r_dvs};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_quo <= '0;
      r_rem <= '0;
      r_dvs <= '0;
    end else if (i_load) begin
      r_quo <= i_dividend;
      r_rem <= '0;
      r_dvs <= i_divisor;
    end else if (i_step) begin
      r_quo <= {r_quo[WIDTH-2:0], w_ok};
      r_rem <= w_ok ? w_diff[WIDTH-1:0]
                    : w_part[WIDTH-1:0];
    end
  end

  assign o_quo = r_quo;
  assign o_rem = r_rem;

endmodule

// File: rtl/md_unit.sv
// Iterative multiply/divide unit with HI/LO registers.
// Build option: MD_FAST_MUL_EN makes MULT/MULTU single-cycle.
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  md_state_e r_state;
  md_state_e w_state_nx;
  md_op_e    r_op;
  md_op_e    w_op;

  logic [CNT_W-1:0]   r_cnt;
  logic               r_neg;
  logic               r_rsign;
  logic               r_dz;
  logic               r_done;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [2*WIDTH-1:0] r_acc;

  logic               w_load;
  logic               w_step;
  logic               w_fix;
  logic               w_fast;
  logic               w_sgn;
  logic               w_isdiv;
  logic               w_rdiv;
  logic [WIDTH-1:0]   w_amag;
  logic [WIDTH-1:0]   w_bmag;
  logic [WIDTH:0]     w_psum;
  logic [2*WIDTH-1:0] w_acc_init;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_qfix;
  logic [WIDTH-1:0]   w_rfix;

  assign w_op    = md_op_e'(op);
  assign w_sgn   = md_is_signed(w_op);
  assign w_isdiv = md_is_div(w_op);
  assign w_rdiv  = md_is_div(r_op);

  assign w_amag = (w_sgn && rs_val[WIDTH-1])
                ? -rs_val : rs_val;
  assign w_bmag = (w_sgn && rt_val[WIDTH-1])
                ? -rt_val : rt_val;

`ifdef MD_FAST_MUL_EN
  assign w_fast = !w_isdiv;
  assign w_acc_init = w_fast
    ? {{WIDTH{1'b0}}, w_amag} * {{WIDTH{1'b0}}, w_bmag}
    : {{WIDTH{1'b0}}, w_bmag};
`else
  assign w_fast     = 1'b0;
  assign w_acc_init = {{WIDTH{1'b0}}, w_bmag};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= MD_IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_load     = 1'b0;
    w_step     = 1'b0;
    w_fix      = 1'b0;
    unique case (r_state)
      MD_IDLE: begin
        if (start) begin
          w_load     = 1'b1;
          w_state_nx = w_fast ? MD_FIX : MD_ITER;
        end
      end
      MD_ITER: begin
        w_step = 1'b1;
        if (r_cnt == CNT_W'(1)) w_state_nx = MD_FIX;
      end
      MD_FIX: begin
        w_fix      = 1'b1;
        w_state_nx = MD_IDLE;
      end
      default: w_state_nx = MD_IDLE;
    endcase
  end

  // Shift-add: low half holds the remaining multiplier bits.
  assign w_psum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                + (r_acc[0] ? {1'b0, r_mcand} : '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_op    <= MD_MULT;
      r_neg   <= 1'b0;
      r_rsign <= 1'b0;
      r_dz    <= 1'b0;
      r_mcand <= '0;
      r_acc   <= '0;
    end else if (w_load) begin
      r_cnt   <= CNT_W'(WIDTH);
      r_op    <= w_op;
      r_neg   <= w_sgn & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
      r_rsign <= w_sgn & rs_val[WIDTH-1];
      r_dz    <= (rt_val == '0);
      r_mcand <= w_amag;
      r_acc   <= w_acc_init;
    end else if (w_step) begin
      r_cnt <= r_cnt - CNT_W'(1);
      if (!w_rdiv) r_acc <= {w_psum, r_acc[WIDTH-1:1]};
    end
  end

  md_div_core #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk       (clk),
    .rst_n     (reset),
    .i_load    (w_load & w_isdiv),
    .i_step    (w_step & w_rdiv),
    .i_dividend(w_amag),
    .i_divisor (w_bmag),
    .o_quo     (w_quo),
    .o_rem     (w_rem)
  );

  assign w_prod = r_neg ? -r_acc : r_acc;
  assign w_qfix = r_dz  ? WIDTH'(MD_DIVZERO_LO)
                : (r_neg ? -w_quo : w_quo);
  assign w_rfix = r_rsign ? -w_rem : w_rem;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_fix;
      if (w_fix) begin
        if (w_rdiv) begin
          r_hi <= w_rfix;
          r_lo <= w_qfix;
        end else begin
          r_hi <= w_prod[2*WIDTH-1:WIDTH];
          r_lo <= w_prod[WIDTH-1:0];
        end
      end else if (r_state == MD_IDLE && !start) begin
        if (mthi) r_hi <= wdata;
        if (mtlo) r_lo <= wdata;
      end
    end
  end

  assign busy = (r_state != MD_IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Iterative multiply/divide unit with the architectural HI/LO registers.
- Sits directly downstream of the register file: consumes the RD1/RD2 operand values (rs/rt) for MULT, MULTU, DIV and DIVU.
- Its hi/lo outputs feed the writeback mux that drives register-file write data for MFHI/MFLO.
- Raises busy so the pipeline stalls any MFHI/MFLO or new MD op issued before the result is ready.

Parameters:
- WIDTH, 32, operand/HI/LO width.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  launch the operation selected by op, using rs_val/rt_val.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- rs_val  in  WIDTH  operand A (multiplicand/dividend), from RD1.
- rt_val  in  WIDTH  operand B (multiplier/divisor), from RD2.
- mthi  in  1  write wdata to HI.
- mtlo  in  1  write wdata to LO.
- wdata  in  WIDTH  MTHI/MTLO data.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse: HI/LO just updated by an MD op.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, hi=0, lo=0, busy=0, done=0, counter=0. Takes effect immediately, including mid-operation; the partial result is discarded.
- States: IDLE -> ITER -> FIX -> IDLE.
- IDLE: start=1 at edge E0 latches the operand magnitudes, the signs (MULT/DIV only; MULTU/DIVU treat operands as unsigned) and op; moves to ITER with counter=WIDTH. busy=1 from E0.
- ITER: one bit per cycle, edges E1..E32.
  - Multiply: radix-2 shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract producing quotient and remainder.
  - Counter decrements each edge; at 0 go to FIX.
- FIX, edge E33:
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Write hi = product[63:32] / remainder and lo = product[31:0] / quotient.
  - Return to IDLE: busy=0 and done=1 for the cycle after E33.
  - Latency: start edge to HI/LO valid = 33 edges.
- Divide by zero: no trap. hi = rs_val, lo = 32'hFFFFFFFF, normal latency, for both DIV and DIVU.
- DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0. This falls out of the magnitude algorithm; no special case.
- start while busy: ignored, not queued.
- mthi/mtlo:
  - Accepted only in IDLE with start=0; register updated at that edge.
  - Both asserted together: both registers get wdata.
  - Dropped while busy, or in the same cycle as an accepted start (start has priority).
- done never asserts for MTHI/MTLO.
- hi/lo hold their value during ITER; the stall is the consumer's responsibility.

Optional Feature:
- Macro: MD_FAST_MUL_EN.
- Defined:
  - MULT/MULTU use a single-cycle full-width multiply: E0 accepts, E1 writes hi/lo.
  - busy is high for exactly one cycle and done pulses the cycle after E1.
  - DIV/DIVU are unchanged (33 edges).
- Undefined: all ops use the iterative 33-edge path, with no multiplier inferred.

Decomposition:
- Package md_pkg holds:
  - typedef enum md_op_e {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
  - typedef enum md_state_e {MD_IDLE, MD_ITER, MD_FIX};
  - constant MD_DIVZERO_LO = 32'hFFFFFFFF.
- One sub-module is natural: md_div_core, the restoring divider datapath (shift/subtract step plus quotient/remainder registers).
- Multiply, sign fix, FSM and HI/LO stay in md_unit.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> busy=1 for 33 cycles, then done pulse; hi=0xFFFFFFFE, lo=0x00000001.
- MULT 0xFFFFFFFD (-3) x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. With MD_FAST_MUL_EN: same values, done 2 cycles after start.
- DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 5 / 0 -> hi=0x00000005, lo=0xFFFFFFFF after 33 edges, done pulses once.
- IDLE: mthi with wdata=0x00001234 -> hi=0x00001234 next edge, done stays 0. During a DIV, a second start and an mtlo are both ignored and the DIV result is unaffected.
- reset driven low at cycle 10 of a DIVU -> busy, done, hi, lo = 0 immediately without a clock edge. After release, MULTU 3 x 4 -> lo=12, hi=0.
